// File: rtl/rpc_config_path_pkg.sv
// Shared configuration types and power-up defaults for the periodic command timer.
package rpc_config_path_pkg;

  localparam int CFG_CMD_W = 19;
  localparam int CFG_INT_W = 25;
  localparam int MAX_CH    = 8;

  typedef struct packed {
    logic                 enable;
    logic [CFG_CMD_W-1:0] cmd;
    logic [CFG_INT_W-1:0] interval;
  } cmd_timer_cfg_t;

  typedef enum logic [1:0] {POWER_UP, INIT, RUN} timer_state_e;

  // Entries past NUM_CH are ignored; channels 0/1 run by default.
  localparam cmd_timer_cfg_t CMD_TIMER_DEFAULT_SETTING [MAX_CH] = '{
    '{1'b1, 19'h0A5A5, 25'd1},
    '{1'b1, 19'h1C3C3, 25'd2},
    '{1'b0, 19'h00000, 25'd0},
    '{1'b0, 19'h00000, 25'd0},
    '{1'b0, 19'h00000, 25'd0},
    '{1'b0, 19'h00000, 25'd0},
    '{1'b0, 19'h00000, 25'd0},
    '{1'b0, 19'h00000, 25'd0}
  };

endpackage

// File: rtl/cmd_timer_channel.sv
// One periodic command channel: config buffer, active config, period counter,
// saturating owed-command count and sticky overflow flag.
module cmd_timer_channel
  import rpc_config_path_pkg::*;
#(
  parameter int             CNT_WIDTH      = 32,
  parameter int             INTERVAL_SHIFT = 7,
  parameter int             MAX_PENDING    = 4,
  parameter cmd_timer_cfg_t DEFAULT_CFG    = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 init_i,
  input  logic                 run_i,
  input  logic                 load_i,
  input  cmd_timer_cfg_t       cfg_i,
  input  logic                 accept_i,
  input  logic                 lock_i,
  output logic                 pend_o,
  output logic [CFG_CMD_W-1:0] cmd_o,
  output logic                 overflow_o
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int FW = CFG_INT_W + INTERVAL_SHIFT;

  cmd_timer_cfg_t         buf_q, act_q;
  logic                   buf_vld_q, ovf_q;
  logic [CNT_WIDTH-1:0]   cnt_q, ceil;
  logic [FW-1:0]          ceil_full;
  logic [PW-1:0]          pend_q;
  logic                   active, tick, apply;

  assign ceil_full = FW'(act_q.interval) << INTERVAL_SHIFT;
  assign ceil      = CNT_WIDTH'(ceil_full);
  assign active    = act_q.enable && (ceil != '0);
  assign tick      = run_i && active && (cnt_q == ceil - CNT_WIDTH'(1));
  // A stalled grant must keep presenting the same word, so it blocks the swap.
  assign apply     = run_i && buf_vld_q && (pend_q == '0) && !lock_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      act_q     <= '0;
      cnt_q     <= '0;
      pend_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (load_i) begin
        buf_q     <= cfg_i;
        buf_vld_q <= 1'b1;
      end else if (init_i || apply) begin
        buf_vld_q <= 1'b0;
      end
      if (init_i) begin
        act_q  <= buf_vld_q ? buf_q : DEFAULT_CFG;
        cnt_q  <= '0;
        pend_q <= '0;
      end else begin
        if (apply) act_q <= buf_q;
        if (apply || tick || !run_i || !active) cnt_q <= '0;
        else                                    cnt_q <= cnt_q + CNT_WIDTH'(1);
        case ({tick, accept_i})
          2'b10: begin
            if (pend_q == PW'(MAX_PENDING)) ovf_q  <= 1'b1;
            else                            pend_q <= pend_q + PW'(1);
          end
          2'b01:   pend_q <= pend_q - PW'(1);
          default: ;
        endcase
      end
    end
  end

  assign pend_o     = (pend_q != '0);
  assign cmd_o      = act_q.cmd;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/multi_cmd_timer.sv
// Periodic multi-channel command generator: global start-up FSM, round-robin
// arbitration over owed commands and a valid/ready output that holds while stalled.
module multi_cmd_timer
  import rpc_config_path_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int CNT_WIDTH      = 32,
  parameter int CMD_WIDTH      = CFG_CMD_W,
  parameter int INTERVAL_SHIFT = 7,
  parameter int MAX_PENDING    = 4,
  localparam int CHW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 init_timer_i,
  input  logic [NUM_CH-1:0]    load_config_i,
  input  cmd_timer_cfg_t       config_i [NUM_CH],
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output logic [CMD_WIDTH-1:0] cmd_o,
  output logic [CHW-1:0]       cmd_ch_o,
  output logic [NUM_CH-1:0]    overflow_o
);

  timer_state_e         state_q, state_d;
  logic [NUM_CH-1:0]    pend, accept, lock;
  logic [CFG_CMD_W-1:0] cmds [NUM_CH];
  logic                 hold_q, valid, found;
  logic [CHW-1:0]       hold_ch_q, rr_q, grant;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= POWER_UP;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      POWER_UP: if (init_timer_i) state_d = INIT;
      INIT:     state_d = RUN;
      RUN:      state_d = RUN;
      default:  state_d = POWER_UP;
    endcase
  end

  // First owed channel at or after the round-robin pointer; a stall pins the grant.
  always_comb begin
    grant = rr_q;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && pend[CHW'((int'(rr_q) + k) % NUM_CH)]) begin
        grant = CHW'((int'(rr_q) + k) % NUM_CH);
        found = 1'b1;
      end
    end
    if (hold_q) grant = hold_ch_q;
  end

  assign valid = hold_q || (|pend);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q    <= 1'b0;
      hold_ch_q <= '0;
      rr_q      <= '0;
    end else begin
      hold_q    <= valid && !cmd_ready_i;
      hold_ch_q <= grant;
      if (valid && cmd_ready_i)
        rr_q <= (grant == CHW'(NUM_CH - 1)) ? '0 : grant + CHW'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign accept[i] = valid && cmd_ready_i && (grant == CHW'(i));
    assign lock[i]   = hold_q && (hold_ch_q == CHW'(i));

    cmd_timer_channel #(
      .CNT_WIDTH     (CNT_WIDTH),
      .INTERVAL_SHIFT(INTERVAL_SHIFT),
      .MAX_PENDING   (MAX_PENDING),
      .DEFAULT_CFG   (CMD_TIMER_DEFAULT_SETTING[i])
    ) u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .init_i    (state_q == INIT),
      .run_i     (state_q == RUN),
      .load_i    (load_config_i[i]),
      .cfg_i     (config_i[i]),
      .accept_i  (accept[i]),
      .lock_i    (lock[i]),
      .pend_o    (pend[i]),
      .cmd_o     (cmds[i]),
      .overflow_o(overflow_o[i])
    );
  end

  assign cmd_valid_o = valid;
  assign cmd_o       = valid ? cmds[grant][CMD_WIDTH-1:0] : '0;
  assign cmd_ch_o    = valid ? grant : '0;

endmodule

// File: tb/tb_multi_cmd_timer.sv
// Randomized bench for multi_cmd_timer against a tick-time/queue-count reference model.
module tb_multi_cmd_timer;
  import rpc_config_path_pkg::*;

  localparam int N    = 2;
  localparam int MAXP = 4;
  localparam int CHW  = 1;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              init_timer_i = 1'b0;
  logic [N-1:0]      load_config_i = '0;
  cmd_timer_cfg_t    config_i [N];
  logic              cmd_valid_o;
  logic              cmd_ready_i = 1'b0;
  logic [18:0]       cmd_o;
  logic [CHW-1:0]    cmd_ch_o;
  logic [N-1:0]      overflow_o;

  multi_cmd_timer #(.NUM_CH(N), .MAX_PENDING(MAXP)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .init_timer_i (init_timer_i),
    .load_config_i(load_config_i),
    .config_i     (config_i),
    .cmd_valid_o  (cmd_valid_o),
    .cmd_ready_i  (cmd_ready_i),
    .cmd_o        (cmd_o),
    .cmd_ch_o     (cmd_ch_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: ticks happen when (t - base) is one short of a multiple of the period.
  int             m_state;
  bit             m_bv [N];
  cmd_timer_cfg_t m_buf [N];
  cmd_timer_cfg_t m_act [N];
  longint         m_base [N];
  int             m_pend [N];
  bit   [N-1:0]   m_ovf;
  bit             m_hold;
  int             m_hch, m_rr;
  longint         t;

  function automatic longint ceil_of(cmd_timer_cfg_t c);
    return (longint'(c.interval) << 7) & 64'hFFFF_FFFF;
  endfunction

  function automatic void m_out(output bit v, output int g);
    v = m_hold;
    g = m_hold ? m_hch : 0;
    if (!m_hold) begin
      for (int k = 0; k < N; k++) begin
        if (!v && m_pend[(m_rr + k) % N] > 0) begin
          v = 1;
          g = (m_rr + k) % N;
        end
      end
    end
  endfunction

  task automatic model_reset();
    m_state = 0; m_hold = 0; m_hch = 0; m_rr = 0; t = 0; m_ovf = '0;
    for (int i = 0; i < N; i++) begin
      m_bv[i] = 0; m_buf[i] = '0; m_act[i] = '0; m_base[i] = 0; m_pend[i] = 0;
    end
  endtask

  task automatic model_step();
    bit v, acc, tick, dec, app;
    int g;
    longint c;
    m_out(v, g);
    acc = v && cmd_ready_i;
    for (int i = 0; i < N; i++) begin
      if (m_state == 1) begin
        m_act[i]  = m_bv[i] ? m_buf[i] : CMD_TIMER_DEFAULT_SETTING[i];
        m_base[i] = t + 1;
        m_pend[i] = 0;
        m_bv[i]   = 0;
      end else if (m_state == 2) begin
        c    = ceil_of(m_act[i]);
        tick = m_act[i].enable && c != 0 && ((t - m_base[i]) % c == c - 1);
        dec  = acc && g == i;
        app  = m_bv[i] && m_pend[i] == 0 && !(m_hold && m_hch == i);
        if (tick && !dec) begin
          if (m_pend[i] == MAXP) m_ovf[i] = 1;
          else                   m_pend[i]++;
        end else if (dec && !tick) begin
          m_pend[i]--;
        end
        if (app) begin
          m_act[i]  = m_buf[i];
          m_base[i] = t + 1;
          m_bv[i]   = 0;
        end
      end
      if (load_config_i[i]) begin
        m_buf[i] = config_i[i];
        m_bv[i]  = 1;
      end
    end
    m_hold = v && !cmd_ready_i;
    m_hch  = g;
    if (acc) m_rr = (g + 1) % N;
    if (m_state == 0 && init_timer_i) m_state = 1;
    else if (m_state == 1)            m_state = 2;
    t++;
  endtask

  task automatic compare_outputs();
    bit v;
    int g;
    m_out(v, g);
    check("valid", cmd_valid_o, v);
    if (v) begin
      check("cmd", cmd_o, m_act[g].cmd);
      check("ch", cmd_ch_o, g);
    end
    check("ovf", overflow_o, m_ovf);
  endtask

  function automatic cmd_timer_cfg_t rand_cfg();
    cmd_timer_cfg_t c;
    int r;
    c.enable = ($urandom_range(9) != 0);
    c.cmd    = 19'($urandom);
    r = $urandom_range(7);
    case (r)
      0:       c.interval = 25'd0;
      1, 2:    c.interval = 25'd1;
      3, 4:    c.interval = 25'd2;
      5:       c.interval = 25'd3;
      6:       c.interval = 25'd4;
      default: c.interval = 25'h1FFFFFF;
    endcase
    return c;
  endfunction

  // rmode: 0 stall, 1 always ready, 2 ready half the time, 3 ready rarely
  task automatic cycle(bit init, int rmode, int lpct);
    @(negedge clk_i);
    compare_outputs();
    init_timer_i = init;
    case (rmode)
      0:       cmd_ready_i = 1'b0;
      1:       cmd_ready_i = 1'b1;
      2:       cmd_ready_i = 1'($urandom_range(1));
      default: cmd_ready_i = ($urandom_range(4) == 0);
    endcase
    for (int i = 0; i < N; i++) begin
      load_config_i[i] = ($urandom_range(99) < lpct);
      config_i[i]      = rand_cfg();
    end
    model_step();
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    init_timer_i = 1'b0; cmd_ready_i = 1'b0; load_config_i = '0;
    #1;
    check("rst_valid", cmd_valid_o, 0);
    check("rst_cmd", cmd_o, 0);
    check("rst_ch", cmd_ch_o, 0);
    check("rst_ovf", overflow_o, 0);
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic episode(int pre, int ncyc, int rmode, int lpct_pre, int lpct_run);
    apply_reset();
    for (int c = 0; c < pre; c++) cycle(0, rmode, lpct_pre);
    cycle(1, rmode, lpct_pre);
    for (int c = 0; c < ncyc; c++) cycle(0, rmode, lpct_run);
  endtask

  initial begin
    int first;
    bit v;
    int g;
    for (int i = 0; i < N; i++) config_i[i] = '0;

    // Defaults only, always ready: first command lands 128 cycles into RUN.
    apply_reset();
    cycle(1, 1, 0);
    first = -1;
    for (int c = 1; c < 400; c++) begin
      cycle(0, 1, 0);
      if (first < 0 && cmd_valid_o === 1'b1) first = c;
    end
    check("first_valid_cycle", first, 130);

    // Long stall on defaults: saturation, overflow, stable word, then alternation.
    apply_reset();
    cycle(1, 0, 0);
    for (int c = 0; c < 1200; c++) cycle(0, 0, 0);
    check("sat_ovf0", overflow_o[0], 1);
    for (int c = 0; c < 300; c++) cycle(0, 1, 0);

    // Random configs, loads racing init and during RUN, assorted back-pressure.
    episode(3, 1500, 2, 60, 1);
    episode(0, 1500, 3, 100, 2);
    episode(5, 1500, 1, 30, 2);
    episode(2, 1500, 2, 50, 3);
    episode(1, 1500, 3, 80, 1);

    // Reset while a command is stalled, then restart from defaults.
    apply_reset();
    cycle(1, 0, 0);
    m_out(v, g);
    for (int c = 0; c < 400 && !v; c++) begin
      cycle(0, 0, 0);
      m_out(v, g);
    end
    check("stall_reached", v, 1);
    @(negedge clk_i);
    check("stall_valid", cmd_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    check("midreset_valid", cmd_valid_o, 0);
    check("midreset_cmd", cmd_o, 0);
    check("midreset_ch", cmd_ch_o, 0);
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    cycle(1, 1, 0);
    for (int c = 0; c < 600; c++) cycle(0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
